// File: rtl/msync_gen.sv
// Master sync generator. It picks a trigger source (internal timer, quadrature wheel
// or external sync), tracks the wheel position, and emits fixed-width low pulses.

// A 2-FF synchronizer followed by a run-length filter. The output takes the new level
// only after FILT_LEN consecutive samples that all differ from the current level.
module msync_filt #(
  parameter int       FILT_LEN = 4,
  parameter logic     RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(FILT_LEN + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      dout <= RST_VAL;
      cnt  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module msync_gen #(
  parameter int FILT_LEN = 4,
  parameter int PULSE_W  = 10,
  parameter int MIN_GAP  = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_adp,
  input  logic               i_bdp,
  input  logic               i_sync,
  input  logic [1:0]         i_mode,
  input  logic [23:0]        i_period,
  input  logic [7:0]         i_step_div,
  input  logic               i_dir_sel,
  output logic               o_msync_n,
  output logic signed [31:0] o_pos,
  output logic               o_dir,
  output logic [15:0]        o_sync_cnt,
  output logic               o_err,
  output logic               o_ovr
);
  localparam int          GW       = $clog2(MIN_GAP + 1);
  localparam logic [2:0]  RST_MASK = 3'b100;   // {sync, b, a}: sync idles high

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  logic [2:0] raw, filt, filt_q;
  assign raw = {i_sync, i_bdp, i_adp};

  for (genvar g = 0; g < 3; g++) begin : g_filt
    msync_filt #(.FILT_LEN(FILT_LEN), .RST_VAL(RST_MASK[g])) u_filt (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (raw[g]),
      .dout (filt[g])
    );
  end

  // Map {A,B} onto a 2-bit Gray position so forward motion is +1 mod 4.
  logic [1:0] idx_new, idx_old, idx_diff;
  logic       fwd, rev, qerr, qual, sync_fall;
  assign idx_new   = {filt[1],   filt[0]   ^ filt[1]};
  assign idx_old   = {filt_q[1], filt_q[0] ^ filt_q[1]};
  assign idx_diff  = idx_new - idx_old;
  assign fwd       = (idx_diff == 2'd1);
  assign rev       = (idx_diff == 2'd3);
  assign qerr      = (idx_diff == 2'd2);
  assign qual      = fwd | (i_dir_sel & rev);
  assign sync_fall = filt_q[2] & ~filt[2];

  logic [1:0]  mode_q;
  logic        mode_chg;
  logic [23:0] per_eff, tmr, tmr_nxt;
  logic [7:0]  div_eff, acc, acc_nxt;
  logic        trig_nxt, trig_q;

  assign mode_chg = (i_mode != mode_q);
  assign per_eff  = (i_period < 24'(MIN_GAP)) ? 24'(MIN_GAP) : i_period;
  assign div_eff  = (i_step_div == 8'd0) ? 8'd1 : i_step_div;

  // Timer uses >= so a period shrunk below the running count still fires.
  always_comb begin
    tmr_nxt  = tmr;
    acc_nxt  = acc;
    trig_nxt = 1'b0;
    if (mode_chg) begin
      tmr_nxt = '0;
      acc_nxt = '0;
    end else begin
      case (i_mode)
        2'b01: begin
          if (i_period == 24'd0) begin
            tmr_nxt = '0;
          end else if (tmr >= per_eff - 24'd1) begin
            trig_nxt = 1'b1;
            tmr_nxt  = '0;
          end else begin
            tmr_nxt = tmr + 24'd1;
          end
        end
        2'b10: begin
          if (qual) begin
            if ({1'b0, acc} + 9'd1 >= {1'b0, div_eff}) begin
              trig_nxt = 1'b1;
              acc_nxt  = '0;
            end else begin
              acc_nxt = acc + 8'd1;
            end
          end
        end
        2'b11:   trig_nxt = sync_fall;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= RST_MASK;
      mode_q <= 2'b00;
      tmr    <= '0;
      acc    <= '0;
      trig_q <= 1'b0;
      o_pos  <= '0;
      o_dir  <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      filt_q <= filt;
      mode_q <= i_mode;
      tmr    <= tmr_nxt;
      acc    <= acc_nxt;
      trig_q <= trig_nxt;
      if (fwd) begin
        o_pos <= o_pos + 32'sd1;
        o_dir <= 1'b1;
      end else if (rev) begin
        o_pos <= o_pos - 32'sd1;
        o_dir <= 1'b0;
      end
      if (qerr) o_err <= 1'b1;
    end
  end

  state_t        st, st_nxt;
  logic [GW-1:0] cnt, cnt_nxt;
  logic          enter, drop;

  // The last GAP cycle may accept a trigger directly so the fall-to-fall spacing
  // is exactly MIN_GAP rather than MIN_GAP+1.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    enter   = 1'b0;
    drop    = 1'b0;
    case (st)
      IDLE: begin
        if (trig_q) begin
          st_nxt  = PULSE;
          cnt_nxt = '0;
          enter   = 1'b1;
        end
      end
      PULSE: begin
        drop = trig_q;
        if (cnt == GW'(PULSE_W - 1)) begin
          st_nxt  = GAP;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GW'(MIN_GAP - PULSE_W - 1)) begin
          cnt_nxt = '0;
          if (trig_q) begin
            st_nxt = PULSE;
            enter  = 1'b1;
          end else begin
            st_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
          drop    = trig_q;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      cnt        <= '0;
      o_msync_n  <= 1'b1;
      o_sync_cnt <= '0;
      o_ovr      <= 1'b0;
    end else begin
      st        <= st_nxt;
      cnt       <= cnt_nxt;
      o_msync_n <= (st_nxt != PULSE);
      if (enter) o_sync_cnt <= o_sync_cnt + 16'd1;
      if (drop)  o_ovr      <= 1'b1;
    end
  end
endmodule

// File: tb/tb_msync_gen.sv
// Directed bench for msync_gen: quadrature table, then timer, wheel, filter,
// error, external-sync and mid-pulse reset sequences.
module tb_msync_gen;
  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_adp, i_bdp, i_sync, i_dir_sel;
  logic [1:0]         i_mode;
  logic [23:0]        i_period;
  logic [7:0]         i_step_div;
  logic               o_msync_n, o_dir, o_err, o_ovr;
  logic signed [31:0] o_pos;
  logic [15:0]        o_sync_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int qi = 0;

  msync_gen dut (
    .clk(clk), .rst_n(rst_n), .i_adp(i_adp), .i_bdp(i_bdp), .i_sync(i_sync),
    .i_mode(i_mode), .i_period(i_period), .i_step_div(i_step_div), .i_dir_sel(i_dir_sel),
    .o_msync_n(o_msync_n), .o_pos(o_pos), .o_dir(o_dir), .o_sync_cnt(o_sync_cnt),
    .o_err(o_err), .o_ovr(o_ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pulse monitor: fall times and low widths.
  int   falls[$];
  int   widths[$];
  int   lowrun = 0;
  logic prev_n = 1'b1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_n && !o_msync_n) falls.push_back(cyc);
      if (!o_msync_n) lowrun++;
      else if (lowrun != 0) begin
        widths.push_back(lowrun);
        lowrun = 0;
      end
    end else lowrun = 0;
    prev_n = o_msync_n;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clr_mon();
    falls.delete();
    widths.delete();
  endtask

  task automatic set_q(input int idx);
    qi = idx & 3;
    i_adp = (qi == 1) || (qi == 2);
    i_bdp = (qi == 2) || (qi == 3);
  endtask

  task automatic chk_width0(input string name);
    if (widths.size() > 0) chk(name, widths[0], 10);
    else chk({name, "_present"}, 0, 1);
  endtask

  typedef struct {
    logic a, b;
    int   pos;
    logic dir;
  } qvec_t;

  qvec_t tbl[10];
  int    c0;

  initial begin
    tbl[0] = '{1, 0, 1, 1};  tbl[1] = '{1, 1, 2, 1};
    tbl[2] = '{0, 1, 3, 1};  tbl[3] = '{0, 0, 4, 1};
    tbl[4] = '{0, 1, 3, 0};  tbl[5] = '{1, 1, 2, 0};
    tbl[6] = '{1, 0, 1, 0};  tbl[7] = '{0, 0, 0, 0};
    tbl[8] = '{0, 1, -1, 0}; tbl[9] = '{0, 0, 0, 1};

    rst_n = 0; i_adp = 0; i_bdp = 0; i_sync = 1; i_mode = 2'b00;
    i_period = 0; i_step_div = 0; i_dir_sel = 0;
    step(3);
    chk("rst_msync_n", o_msync_n, 1);
    chk("rst_pos", o_pos, 0);
    chk("rst_dir", o_dir, 0);
    chk("rst_sync_cnt", o_sync_cnt, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ovr", o_ovr, 0);
    rst_n = 1;
    step(5);

    // Quadrature table in mode 00 (never triggers).
    for (int i = 0; i < 10; i++) begin
      i_adp = tbl[i].a; i_bdp = tbl[i].b;
      step(12);
      chk($sformatf("tbl%0d_pos", i), o_pos, tbl[i].pos);
      chk($sformatf("tbl%0d_dir", i), o_dir, tbl[i].dir);
      chk($sformatf("tbl%0d_msync", i), o_msync_n, 1);
      chk($sformatf("tbl%0d_err", i), o_err, 0);
    end
    set_q(0);

    // Wheel mode: forward only, 4 counts per pulse.
    i_mode = 2'b10; i_step_div = 4; i_dir_sel = 0;
    step(5);
    clr_mon();
    for (int i = 1; i <= 16; i++) begin set_q(i); step(50); end
    step(20);
    chk("wheel_fwd_pulses", falls.size(), 4);
    chk_width0("wheel_width");
    chk("wheel_fwd_pos", o_pos, 16);
    chk("wheel_fwd_dir", o_dir, 1);
    chk("wheel_fwd_cnt", o_sync_cnt, 4);
    clr_mon();
    for (int i = 1; i <= 8; i++) begin set_q(qi - 1); step(50); end
    step(20);
    chk("wheel_rev_pulses", falls.size(), 0);
    chk("wheel_rev_pos", o_pos, 8);
    chk("wheel_rev_dir", o_dir, 0);
    i_dir_sel = 1;
    clr_mon();
    for (int i = 1; i <= 4; i++) begin set_q(qi - 1); step(50); end
    step(20);
    chk("wheel_both_pulses", falls.size(), 1);
    chk("wheel_both_pos", o_pos, 4);
    chk("wheel_both_cnt", o_sync_cnt, 5);
    i_mode = 2'b00; i_dir_sel = 0;
    step(150);

    // Timer, period 1000.
    i_period = 1000; i_mode = 2'b01;
    clr_mon();
    step(3100);
    if (falls.size() >= 3) begin
      chk("tmr1000_int1", falls[1] - falls[0], 1000);
      chk("tmr1000_int2", falls[2] - falls[1], 1000);
    end else chk("tmr1000_falls", falls.size(), 3);
    chk_width0("tmr1000_width");
    i_mode = 2'b00;
    step(200);

    // Timer, period below MIN_GAP is clamped to 100.
    i_period = 20; i_mode = 2'b01;
    clr_mon();
    step(450);
    if (falls.size() >= 3) begin
      chk("tmr20_int1", falls[1] - falls[0], 100);
      chk("tmr20_int2", falls[2] - falls[1], 100);
    end else chk("tmr20_falls", falls.size(), 3);
    chk_width0("tmr20_width");
    chk("tmr20_ovr", o_ovr, 0);
    i_mode = 2'b00;
    step(200);

    // Timer, period 0 disabled.
    i_period = 0; i_mode = 2'b01;
    clr_mon();
    step(400);
    chk("tmr0_pulses", falls.size(), 0);
    i_mode = 2'b00;
    step(5);

    // Filter: 3-cycle glitch ignored, stable change counted.
    clr_mon();
    i_adp = 1; step(3); i_adp = 0; step(15);
    chk("glitch_pos", o_pos, 4);
    i_adp = 1; step(15);
    chk("stable_pos", o_pos, 5);
    i_adp = 0; step(15);
    chk("stable_back_pos", o_pos, 4);
    chk("filter_pulses", falls.size(), 0);

    // Both phases at once: no count, sticky error.
    i_adp = 1; i_bdp = 1; step(15);
    chk("err_pos", o_pos, 4);
    chk("err_set", o_err, 1);
    i_adp = 0; i_bdp = 0; step(15);
    i_adp = 1; step(15);
    chk("err_after_pos", o_pos, 5);
    chk("err_sticky", o_err, 1);
    i_adp = 0; step(15);

    // External: latency 8, second fall dropped.
    i_mode = 2'b11; step(5);
    c0 = o_sync_cnt;
    clr_mon();
    i_sync = 0;
    step(7);
    chk("ext_lat7_high", o_msync_n, 1);
    step(1);
    chk("ext_lat8_low", o_msync_n, 0);
    step(12); i_sync = 1;
    step(30); i_sync = 0;
    step(150);
    chk("ext_pulses", falls.size(), 1);
    chk_width0("ext_width");
    chk("ext_ovr", o_ovr, 1);
    chk("ext_cnt_delta", o_sync_cnt - 16'(c0), 1);
    i_sync = 1; step(20);

    // Reset asserted 3 cycles into a pulse.
    i_sync = 0;
    step(8);
    chk("rstp_low", o_msync_n, 0);
    step(3);
    #2 rst_n = 0;
    #1;
    chk("rstp_async_high", o_msync_n, 1);
    chk("rstp_pos", o_pos, 0);
    chk("rstp_dir", o_dir, 0);
    chk("rstp_cnt", o_sync_cnt, 0);
    chk("rstp_err", o_err, 0);
    chk("rstp_ovr", o_ovr, 0);
    i_sync = 1;
    step(3);
    rst_n = 1;
    step(10);
    clr_mon();
    i_sync = 0;
    step(150);
    chk("post_rst_pulses", falls.size(), 1);
    chk_width0("post_rst_width");
    chk("post_rst_cnt", o_sync_cnt, 1);
    chk("post_rst_ovr", o_ovr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/msync_gen.md
MSYNC_GEN -- requirements
Module: msync_gen

Interface
REQ-001 Parameter FILT_LEN, 4: consecutive equal samples needed to accept a new level on a filtered input.
REQ-002 Parameter PULSE_W, 10: o_msync_n low width in clk cycles; 10 cycles gives 100 ns at 100 MHz, above the 80 ns minimum.
REQ-003 Parameter MIN_GAP, 100: minimum clk cycles from one o_msync_n falling edge to the next.
REQ-004 clk  in  1  system clock, 100 MHz; all logic is in this domain.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_adp, i_bdp  in  1 each  wheel quadrature phases A/B; asynchronous inputs.
REQ-007 i_sync  in  1  external RS422 sync; asynchronous; idle high.
REQ-008 i_mode  in  2  trigger source: 00 off, 01 internal timer, 10 wheel, 11 external.
REQ-009 i_period  in  24  internal timer period in clk cycles.
REQ-010 i_step_div  in  8  wheel counts per sync pulse.
REQ-011 i_dir_sel  in  1  0: only forward counts trigger; 1: counts in either direction trigger.
REQ-012 o_msync_n  out  1  master sync to zond, data and memory-fill stages; active low.
REQ-013 o_pos  out  32  signed wheel position in x4 quadrature counts.
REQ-014 o_dir  out  1  direction of last valid count: 1 forward, 0 reverse.
REQ-015 o_sync_cnt  out  16  count of issued sync pulses.
REQ-016 o_err  out  1  sticky quadrature error.
REQ-017 o_ovr  out  1  sticky dropped-trigger flag.

Function
REQ-018 Synchronizers: i_adp, i_bdp and i_sync shall each pass through a 2-FF synchronizer.
REQ-019 Filter: each synchronized input shall pass through a filter that takes the new level only after FILT_LEN consecutive equal samples; shorter pulses shall have no effect.
REQ-020 Quadrature decode (filtered {A,B}):
- Forward sequence 00->10->11->01->00 gives +1, o_dir=1.
- Reverse of that sequence gives -1, o_dir=0.
- Both phases changing in the same cycle gives no count and sets o_err.
REQ-021 o_pos shall wrap as two's complement with no saturation.
REQ-022 Timer mode (01):
- Counter runs 0..i_period-1 and triggers on the cycle it equals i_period-1, then returns to 0.
- i_period=0 disables triggering.
- i_period<MIN_GAP shall be treated as MIN_GAP.
REQ-023 Wheel mode (10):
- Step accumulator counts qualifying counts per i_dir_sel; non-qualifying counts are ignored.
- Trigger when the accumulator reaches i_step_div, then clear it to 0.
- i_step_div=0 shall be treated as 1.
REQ-024 External mode (11): each falling edge of filtered i_sync shall trigger.
REQ-025 Mode 00 shall never trigger; o_pos shall keep tracking the wheel in every mode.
REQ-026 Any change of i_mode shall clear the timer counter and step accumulator in the same cycle; a pulse already in progress shall complete.
REQ-027 Pulse FSM:
- IDLE: on trigger, go to PULSE.
- PULSE: o_msync_n=0 for exactly PULSE_W cycles, then go to GAP.
- GAP: last MIN_GAP-PULSE_W cycles, then go to IDLE.
REQ-028 A trigger arriving in PULSE or GAP shall be dropped and shall set o_ovr; triggers shall never be queued.
REQ-029 Trigger and IDLE in the same cycle: o_msync_n shall fall on the next clk edge (1-cycle registered latency).
REQ-030 End-to-end latency from a stable input edge to the o_msync_n fall shall be exactly 2+FILT_LEN+2 cycles (8 with defaults).
REQ-031 o_sync_cnt shall increment on each PULSE entry and wrap from 0xFFFF to 0.
REQ-032 o_msync_n shall be a direct register output with no glitches.

Reset
REQ-033 While rst_n=0, all of the following shall hold:
- o_msync_n=1, o_pos=0, o_dir=0, o_sync_cnt=0, o_err=0, o_ovr=0.
- FSM in IDLE; timer counter and step accumulator at 0.
- A/B filters at 0; sync filter at 1; synchronizer flops at the same values as their filters.
REQ-034 Reset asserted mid-pulse shall force o_msync_n=1 immediately, without waiting for a clk edge.
REQ-035 o_err and o_ovr shall clear only on reset.

Verification
REQ-036 Timer: mode 01, i_period=1000 -> o_msync_n falls every 1000 cycles, low exactly 10 cycles; i_period=20 -> falls every 100 cycles.
REQ-037 Wheel: mode 10, i_step_div=4, i_dir_sel=0, 16 forward counts 50 cycles apart -> 4 pulses, o_pos=16, o_dir=1, o_sync_cnt=4; then 8 reverse counts -> 0 pulses, o_pos=8, o_dir=0.
REQ-038 Filter: 3-cycle glitch on i_adp -> o_pos unchanged, no pulse; 4-cycle stable change -> one count.
REQ-039 Error: A and B toggled in the same filtered cycle -> o_pos unchanged, o_err=1 and stays 1.
REQ-040 External: mode 11, two i_sync falls 50 cycles apart -> exactly one pulse, fall 8 cycles after the first edge, o_ovr=1, o_sync_cnt=1.
REQ-041 Reset: rst_n pulled low 3 cycles into a pulse -> o_msync_n=1 asynchronously, all outputs at reset values; next trigger after release -> normal 10-cycle pulse.
